// File: rtl/mmac_seq_pkg.sv
// Shared types and widths for the mmac_seq sequencer and its core-facing datapath.
package mmac_seq_pkg;

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned OUT_W  = 13;

  typedef enum logic [1:0] {
    OP_MIN     = 2'b00,
    OP_MAX     = 2'b01,
    OP_MADD    = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    INIT,
    LOAD,
    RUN,
    CAP,
    RESP,
    DRAIN
  } state_e;

endpackage

// File: rtl/mmac_seq_if.sv
// Command and result handshake bundle; master issues commands, slave (the sequencer) answers.
interface mmac_seq_if;
  import mmac_seq_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [IDX_W-1:0]  cmd_index;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_last;

  logic              res_valid;
  logic              res_ready;
  logic [OUT_W-1:0]  res_data;
  logic              res_err;

  modport master (
    output cmd_valid, cmd_op, cmd_index, cmd_data, cmd_last, res_ready,
    input  cmd_ready, res_valid, res_data, res_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_index, cmd_data, cmd_last, res_ready,
    output cmd_ready, res_valid, res_data, res_err
  );
endinterface

// File: rtl/mmac_seq_perf.sv
// Saturating 16-bit counters of completed result handshakes and busy cycles.
module mmac_seq_perf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        busy,
  input  logic        job_done,
  output logic [15:0] perf_jobs,
  output logic [15:0] perf_busy
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_jobs <= '0;
      perf_busy <= '0;
    end else begin
      if (job_done && perf_jobs != '1) perf_jobs <= perf_jobs + 16'd1;
      if (busy && perf_busy != '1)     perf_busy <= perf_busy + 16'd1;
    end
  end

endmodule

// File: rtl/mmac_seq.sv
// Sequencer for an external min/max/madd core: header, optional load beats, timed run, result.
// Performance counters are present only when MMAC_SEQ_PERF_EN is defined.
module mmac_seq
  import mmac_seq_pkg::*;
#(
  parameter int unsigned RUNW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  mmac_seq_if.slave         bus,
  output logic              core_rst_n,
  output logic [1:0]        core_insn,
  output logic              core_load,
  output logic              core_run,
  output logic [IDX_W-1:0]  core_index,
  output logic [DATA_W-1:0] core_data,
  input  logic [OUT_W-1:0]  core_out,
  output logic              busy,
  output logic [15:0]       perf_jobs,
  output logic [15:0]       perf_busy
);

  state_e           state, state_nxt;
  op_e              op;
  logic [RUNW-1:0]  run_len, cnt;
  logic             hdr_last, load_pend, last_seen, accept;
  logic [OUT_W-1:0] res_data;
  logic             res_err;

  assign accept       = bus.cmd_valid && bus.cmd_ready;
  assign core_load    = load_pend;
  assign bus.res_data = res_data;
  assign bus.res_err  = res_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) begin
               if (op_e'(bus.cmd_op) == OP_ILLEGAL) state_nxt = bus.cmd_last ? RESP : DRAIN;
               else                                  state_nxt = CLR;
             end
      CLR:   state_nxt = INIT;
      INIT:  state_nxt = hdr_last ? RUN : LOAD;
      // Leave only after the pulse for the last beat has been presented.
      LOAD:  if (load_pend && last_seen) state_nxt = RUN;
      RUN:   if (cnt == RUNW'(1)) state_nxt = CAP;
      CAP:   state_nxt = RESP;
      RESP:  if (bus.res_ready) state_nxt = IDLE;
      DRAIN: if (accept && bus.cmd_last) state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.res_valid = 1'b0;
    core_insn     = 2'b00;
    core_run      = 1'b0;
    core_rst_n    = rst_n;
    busy          = 1'b1;
    case (state)
      IDLE:  begin bus.cmd_ready = 1'b1; busy = 1'b0; end
      CLR:   core_rst_n = 1'b0;
      INIT:  core_insn = op;
      LOAD:  begin bus.cmd_ready = !load_pend; core_insn = op; end
      RUN:   begin core_insn = op; core_run = 1'b1; end
      CAP:   core_insn = op;
      RESP:  bus.res_valid = 1'b1;
      DRAIN: bus.cmd_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op         <= OP_MIN;
      run_len    <= '0;
      hdr_last   <= 1'b0;
      cnt        <= '0;
      load_pend  <= 1'b0;
      last_seen  <= 1'b0;
      core_index <= '0;
      core_data  <= '0;
      res_data   <= '0;
      res_err    <= 1'b0;
    end else begin
      load_pend <= (state == LOAD) && accept;
      if (state == IDLE && accept) begin
        op        <= op_e'(bus.cmd_op);
        run_len   <= (bus.cmd_index == '0) ? RUNW'(16) : RUNW'(bus.cmd_index);
        hdr_last  <= bus.cmd_last;
        last_seen <= 1'b0;
      end
      if (state == LOAD && accept) begin
        core_index <= bus.cmd_index;
        core_data  <= bus.cmd_data;
        last_seen  <= bus.cmd_last;
      end
      if (state_nxt == RUN && state != RUN) cnt <= run_len;
      else if (state == RUN)                cnt <= cnt - RUNW'(1);
      // Error responses (illegal op) enter RESP from anywhere but CAP.
      if (state == CAP) begin
        res_data <= core_out;
        res_err  <= 1'b0;
      end else if (state_nxt == RESP && state != RESP) begin
        res_data <= '0;
        res_err  <= 1'b1;
      end
    end
  end

`ifdef MMAC_SEQ_PERF_EN
  logic job_done;
  assign job_done = bus.res_valid && bus.res_ready;

  mmac_seq_perf u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .busy      (busy),
    .job_done  (job_done),
    .perf_jobs (perf_jobs),
    .perf_busy (perf_busy)
  );
`else
  assign perf_jobs = '0;
  assign perf_busy = '0;
`endif

endmodule
